// File: rtl/axi_sram_slave_if.sv
// AXI4 subset bus bundle between a core master port and the SRAM responder.
// Single clock domain; the clock and reset stay outside the interface.
interface axi_sram_slave_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    // Write address channel
    logic                awready;
    logic                awvalid;
    logic [ADDR_LEN-1:0] awaddr;
    logic [3:0]          awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;

    // Write data channel
    logic                wready;
    logic                wvalid;
    logic [DATA_LEN-1:0] wdata;
    logic [3:0]          wstrb;
    logic                wlast;

    // Write response channel
    logic                bready;
    logic                bvalid;
    logic [1:0]          bresp;
    logic [3:0]          bid;

    // Read address channel
    logic                arready;
    logic                arvalid;
    logic [ADDR_LEN-1:0] araddr;
    logic [3:0]          arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;

    // Read data channel
    logic                rready;
    logic                rvalid;
    logic [1:0]          rresp;
    logic [DATA_LEN-1:0] rdata;
    logic                rlast;
    logic [3:0]          rid;

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rresp, rdata, rlast, rid
    );

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rresp, rdata, rlast, rid
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 INCR-burst responder over a single-ported word SRAM, one transaction
// at a time; reads win over writes when both arrive together.
module axi_sram_slave #(
    parameter int                  ADDR_LEN  = 32,
    parameter int                  DATA_LEN  = 32,
    parameter int                  DEPTH     = 1024,
    parameter logic [ADDR_LEN-1:0] BASE_ADDR = 32'h8000_0000
) (
    input logic             clock,
    input logic             reset,
    axi_sram_slave_if.slave bus
);
    localparam int         IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SLV   = 2'b10;
    localparam logic [1:0] RESP_DEC   = 2'b11;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {IDLE, RD, WR, BRESP} state_t;

    state_t state, state_next;

    logic [ADDR_LEN-1:0] addr_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic                bad_q;
    logic [1:0]          wr_err_q;
    logic [DATA_LEN-1:0] rdata_q;
    logic [1:0]          rresp_q;
    logic                rlast_q;
    logic [3:0]          rid_q;
    logic [3:0]          bid_q;
    logic [1:0]          bresp_q;

    logic [DATA_LEN-1:0] mem [DEPTH];

    logic                arready, awready, wready, rvalid, bvalid;
    logic                ar_hs, aw_hs, r_adv, w_beat, load_rd;
    logic                ar_bad, aw_bad;
    logic [ADDR_LEN-1:0] beat_addr;
    logic                beat_bad, beat_last;
    logic [1:0]          w_resp;

    // Decode is relative to BASE_ADDR; addresses below the base wrap to a
    // huge offset and so fall out of range naturally.
    function automatic logic in_range(input logic [ADDR_LEN-1:0] a);
        return ((a - BASE_ADDR) >> 2) < ADDR_LEN'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_LEN-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // Response codes are ordered so that the numerically larger one is worse.
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        arready    = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        rvalid     = 1'b0;
        bvalid     = 1'b0;
        unique case (state)
            IDLE: begin
                arready = 1'b1;
                awready = ~bus.arvalid;
                if (bus.arvalid)      state_next = RD;
                else if (bus.awvalid) state_next = WR;
            end
            RD: begin
                rvalid = 1'b1;
                if (bus.rready && rlast_q) state_next = IDLE;
            end
            WR: begin
                wready = 1'b1;
                if (bus.wvalid && bus.wlast) state_next = BRESP;
            end
            BRESP: begin
                bvalid = 1'b1;
                if (bus.bready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ar_hs   = (state == IDLE) && bus.arvalid;
        aw_hs   = (state == IDLE) && bus.awvalid && !bus.arvalid;
        r_adv   = (state == RD) && bus.rready && !rlast_q;
        w_beat  = (state == WR) && bus.wvalid;
        load_rd = ar_hs || r_adv;

        ar_bad  = (bus.arburst != BURST_INCR) || (bus.arsize > 3'd2);
        aw_bad  = (bus.awburst != BURST_INCR) || (bus.awsize > 3'd2);

        // The read data register is loaded one beat ahead: from araddr on the
        // AR handshake, from the next address on each accepted non-last beat.
        beat_addr = ar_hs ? bus.araddr : addr_q + ADDR_LEN'(4);
        beat_bad  = ar_hs ? ar_bad : bad_q;
        beat_last = ar_hs ? (bus.arlen == 8'd0) : (8'(cnt_q + 8'd1) == len_q);

        // A wlast that disagrees with the beat counter, early or late, is SLVERR.
        if (!in_range(addr_q))
            w_resp = RESP_DEC;
        else if (bad_q || (bus.wlast != (cnt_q == len_q)))
            w_resp = RESP_SLV;
        else
            w_resp = RESP_OKAY;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
            wr_err_q <= RESP_OKAY;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
            rid_q    <= '0;
            bid_q    <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                rid_q  <= bus.arid;
                addr_q <= bus.araddr;
                len_q  <= bus.arlen;
                cnt_q  <= '0;
                bad_q  <= ar_bad;
            end else if (aw_hs) begin
                bid_q    <= bus.awid;
                addr_q   <= bus.awaddr;
                len_q    <= bus.awlen;
                cnt_q    <= '0;
                bad_q    <= aw_bad;
                wr_err_q <= RESP_OKAY;
            end else if (r_adv || w_beat) begin
                addr_q <= addr_q + ADDR_LEN'(4);
                cnt_q  <= cnt_q + 8'd1;
            end

            if (load_rd) begin
                rdata_q <= (in_range(beat_addr) && !beat_bad) ? mem[word_idx(beat_addr)] : '0;
                rresp_q <= !in_range(beat_addr) ? RESP_DEC : (beat_bad ? RESP_SLV : RESP_OKAY);
                rlast_q <= beat_last;
            end

            if (w_beat) begin
                wr_err_q <= worst(wr_err_q, w_resp);
                if (bus.wlast) bresp_q <= worst(wr_err_q, w_resp);
            end
        end
    end

    // NOTE: the array is deliberately left out of reset; clearing a RAM would
    // need a sweep, and words written before a mid-burst reset must survive.
    always_ff @(posedge clock) begin
        if (!reset && w_beat && !bad_q && in_range(addr_q)) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) mem[word_idx(addr_q)][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    assign bus.arready = arready;
    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.rvalid  = rvalid;
    assign bus.bvalid  = bvalid;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = rid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bid     = bid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: write/read, bursts with backpressure,
// strobes, range edge, collision, burst errors and reset mid-read.
module tb_axi_sram_slave;
    logic clock = 1'b0;
    logic reset;

    axi_sram_slave_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

    axi_sram_slave #(
        .ADDR_LEN (32),
        .DATA_LEN (32),
        .DEPTH    (1024),
        .BASE_ADDR(32'h8000_0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] wbuf    [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    int          rd_beats;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic idle_master();
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0;
        bus.awsize  = 3'd2; bus.awburst = 2'b01;
        bus.wvalid  = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
        bus.arsize  = 3'd2; bus.arburst = 2'b01;
        bus.rready  = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input int nbeats, input logic [3:0] strb, input logic [1:0] burst);
        bit seen;
        bus.awaddr = addr; bus.awid = id; bus.awlen = len;
        bus.awsize = 3'd2; bus.awburst = burst; bus.awvalid = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clock);
            seen = bus.awready;
        end
        check("aw_handshake", 32'(seen), 32'd1);
        @(posedge clock); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            bus.wvalid = 1'b1; bus.wdata = wbuf[i]; bus.wstrb = strb;
            bus.wlast  = (i == nbeats - 1);
            seen = 1'b0;
            for (int n = 0; n < 100 && !seen; n++) begin
                @(negedge clock);
                seen = bus.wready;
            end
            check("w_handshake", 32'(seen), 32'd1);
            @(posedge clock); #1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        bus.bready = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clock);
            seen = bus.bvalid;
        end
        check("b_handshake", 32'(seen), 32'd1);
        b_resp = bus.bresp;
        b_id   = bus.bid;
        @(posedge clock); #1;
        bus.bready = 1'b0;
    endtask

    // pat[cyc % 4] drives rready per cycle; returns after 'stop' accepted beats.
    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [3:0] pat, input int stop);
        bit          seen, stalled;
        logic [31:0] s_data;
        logic [1:0]  s_resp;
        logic        s_last;
        bus.araddr = addr; bus.arid = id; bus.arlen = len;
        bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clock);
            seen = bus.arready;
        end
        check("ar_handshake", 32'(seen), 32'd1);
        check("rvalid_before_ar", 32'(bus.rvalid), 32'd0);
        @(posedge clock); #1;
        bus.arvalid = 1'b0;
        check("rvalid_latency", 32'(bus.rvalid), 32'd1);
        rd_beats = 0;
        stalled  = 1'b0;
        for (int cyc = 0; cyc < 200 && rd_beats < stop; cyc++) begin
            bus.rready = pat[cyc % 4];
            @(negedge clock);
            if (stalled) begin
                check("r_hold_data", bus.rdata, s_data);
                check("r_hold_resp", 32'(bus.rresp), 32'(s_resp));
                check("r_hold_last", 32'(bus.rlast), 32'(s_last));
            end
            stalled = 1'b0;
            if (bus.rvalid) begin
                if (bus.rready) begin
                    rd_data[rd_beats] = bus.rdata;
                    rd_resp[rd_beats] = bus.rresp;
                    rd_last[rd_beats] = bus.rlast;
                    rd_id[rd_beats]   = bus.rid;
                    rd_beats++;
                end else begin
                    stalled = 1'b1;
                    s_data  = bus.rdata;
                    s_resp  = bus.rresp;
                    s_last  = bus.rlast;
                end
            end
            @(posedge clock); #1;
        end
        bus.rready = 1'b0;
        check("r_beat_count", 32'(rd_beats), 32'(stop));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_master();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        check("rst_arready", 32'(bus.arready), 32'd1);
        check("rst_awready", 32'(bus.awready), 32'd1);
        check("rst_wready",  32'(bus.wready),  32'd0);
        check("rst_rvalid",  32'(bus.rvalid),  32'd0);
        check("rst_bvalid",  32'(bus.bvalid),  32'd0);
        check("rst_rdata",   bus.rdata,        32'd0);
        check("rst_rresp",   32'(bus.rresp),   32'd0);
        check("rst_rlast",   32'(bus.rlast),   32'd0);
        check("rst_rid",     32'(bus.rid),     32'd0);
        check("rst_bresp",   32'(bus.bresp),   32'd0);
        check("rst_bid",     32'(bus.bid),     32'd0);

        // Single write then read
        wbuf[0] = 32'hDEAD_BEEF;
        do_write(32'h8000_0010, 4'd1, 8'd0, 1, 4'hF, 2'b01);
        check("single_bresp", 32'(b_resp), 32'd0);
        check("single_bid",   32'(b_id),   32'd1);
        do_read(32'h8000_0010, 4'd0, 8'd0, 4'b1111, 1);
        check("single_rdata", rd_data[0],        32'hDEAD_BEEF);
        check("single_rresp", 32'(rd_resp[0]),   32'd0);
        check("single_rlast", 32'(rd_last[0]),   32'd1);
        check("single_rid",   32'(rd_id[0]),     32'd0);

        // 4-beat burst, read back with rready 1,0,1,0
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        do_write(32'h8000_0100, 4'd2, 8'd3, 4, 4'hF, 2'b01);
        check("burst_bresp", 32'(b_resp), 32'd0);
        do_read(32'h8000_0100, 4'd3, 8'd3, 4'b0101, 4);
        for (int i = 0; i < 4; i++) begin
            check("burst_rdata", rd_data[i], 32'h11 * 32'(i + 1));
            check("burst_rlast", 32'(rd_last[i]), 32'(i == 3));
            check("burst_rid",   32'(rd_id[i]),   32'd3);
        end

        // Byte strobes
        wbuf[0] = 32'hAABB_CCDD;
        do_write(32'h8000_0200, 4'd4, 8'd0, 1, 4'hF, 2'b01);
        wbuf[0] = 32'h1122_3344;
        do_write(32'h8000_0200, 4'd4, 8'd0, 1, 4'b0101, 2'b01);
        check("strb_bresp", 32'(b_resp), 32'd0);
        do_read(32'h8000_0200, 4'd4, 8'd0, 4'b1111, 1);
        check("strb_rdata", rd_data[0], 32'hAA22_CC44);

        // Last word, then one beat past the array
        wbuf[0] = 32'h5A5A_1234;
        do_write(32'h8000_0FFC, 4'd2, 8'd0, 1, 4'hF, 2'b01);
        do_read(32'h8000_0FFC, 4'd6, 8'd1, 4'b1111, 2);
        check("oor_beat0_resp", 32'(rd_resp[0]), 32'd0);
        check("oor_beat0_data", rd_data[0],      32'h5A5A_1234);
        check("oor_beat0_last", 32'(rd_last[0]), 32'd0);
        check("oor_beat1_resp", 32'(rd_resp[1]), 32'd3);
        check("oor_beat1_data", rd_data[1],      32'd0);
        check("oor_beat1_last", 32'(rd_last[1]), 32'd1);

        // AR and AW raised together: read first, awready low until IDLE
        wbuf[0] = 32'hCAFE_F00D;
        do_write(32'h8000_0300, 4'd1, 8'd0, 1, 4'hF, 2'b01);
        bus.araddr = 32'h8000_0300; bus.arid = 4'd7; bus.arlen = 8'd0; bus.arvalid = 1'b1;
        bus.awaddr = 32'h8000_0304; bus.awid = 4'd5; bus.awlen = 8'd0; bus.awvalid = 1'b1;
        @(negedge clock);
        check("coll_arready", 32'(bus.arready), 32'd1);
        check("coll_awready", 32'(bus.awready), 32'd0);
        @(posedge clock); #1;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        check("coll_awready_rd", 32'(bus.awready), 32'd0);
        @(negedge clock);
        check("coll_rvalid", 32'(bus.rvalid),  32'd1);
        check("coll_rdata",  bus.rdata,        32'hCAFE_F00D);
        check("coll_rid",    32'(bus.rid),     32'd7);
        check("coll_awready_beat", 32'(bus.awready), 32'd0);
        @(posedge clock); #1;
        bus.rready = 1'b0;
        check("coll_awready_idle", 32'(bus.awready), 32'd1);
        wbuf[0] = 32'h0BAD_C0DE;
        do_write(32'h8000_0304, 4'd5, 8'd0, 1, 4'hF, 2'b01);
        check("coll_bresp", 32'(b_resp), 32'd0);
        check("coll_bid",   32'(b_id),   32'd5);
        do_read(32'h8000_0304, 4'd0, 8'd0, 4'b1111, 1);
        check("coll_wr_data", rd_data[0], 32'h0BAD_C0DE);

        // awlen 3 but wlast on the third beat
        wbuf[0] = 32'h0101_0101; wbuf[1] = 32'h0202_0202; wbuf[2] = 32'h0303_0303;
        do_write(32'h8000_0400, 4'd6, 8'd3, 3, 4'hF, 2'b01);
        check("short_bresp", 32'(b_resp), 32'd2);
        check("short_bid",   32'(b_id),   32'd6);
        do_read(32'h8000_0400, 4'd0, 8'd0, 4'b1111, 1);
        check("short_kept", rd_data[0], 32'h0101_0101);

        // FIXED burst: SLVERR, array untouched
        wbuf[0] = 32'hFFFF_FFFF;
        do_write(32'h8000_0200, 4'd8, 8'd0, 1, 4'hF, 2'b00);
        check("fixed_bresp", 32'(b_resp), 32'd2);
        do_read(32'h8000_0200, 4'd0, 8'd0, 4'b1111, 1);
        check("fixed_untouched", rd_data[0], 32'hAA22_CC44);

        // Write below the base address
        wbuf[0] = 32'h1234_5678;
        do_write(32'h7FFF_FFFC, 4'd9, 8'd0, 1, 4'hF, 2'b01);
        check("below_base_bresp", 32'(b_resp), 32'd3);

        // Reset during beat 2 of an 8-beat read
        do_read(32'h8000_0100, 4'd9, 8'd7, 4'b1111, 2);
        check("mid_beat0", rd_data[0], 32'h11);
        check("mid_beat1", rd_data[1], 32'h22);
        check("mid_rvalid_before", 32'(bus.rvalid), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mid_rst_rvalid",  32'(bus.rvalid),  32'd0);
        check("mid_rst_arready", 32'(bus.arready), 32'd1);
        check("mid_rst_bvalid",  32'(bus.bvalid),  32'd0);
        do_read(32'h8000_0010, 4'd10, 8'd0, 4'b1111, 1);
        check("post_rst_rdata", rd_data[0],      32'hDEAD_BEEF);
        check("post_rst_rresp", 32'(rd_resp[0]), 32'd0);
        check("post_rst_rlast", 32'(rd_last[0]), 32'd1);
        check("post_rst_rid",   32'(rd_id[0]),   32'd10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
